pea_invoke_scheduler: RTL
=========================

// Module: pea_invoke_scheduler
// PURPOSE
//  Hardware sequencer replacing host-driven firing of PEA_top_module_1. Per instruction, runs the
//  CFDF phase sequence SETUP_INSTR -> INSTR (-> OUTPUT when enabled): drives next_instr, waits for
//  PEA_enable, pulses invoke, waits for FC. Adds instruction count, enable-retry limit, FC timeout
//  watchdog and firing counters.
// PARAMETERS
//  MAX_INSTR    16    max instructions per run; num_instr width = IW = log2(MAX_INSTR+1)
//  CNT_W        16    width of fire_count
//  SETTLE       2     cycles held in new mode before enable is sampled (>=1)
//  EN_RETRY     8     consecutive enable-low cycles tolerated in CHECK_EN before abort
//  FC_TIMEOUT   1024  max cycles in WAIT_FC before abort
//  WITH_OUTPUT  0     1: append OUTPUT (2'b10) phase after each INSTR phase
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active high
//  start       in   1      run request pulse; sampled only in IDLE/ERROR
//  num_instr   in   IW     instructions to execute; latched on accepted start
//  enable      in   1      from PEA_enable
//  FC          in   1      firing complete from PEA_top_module_1
//  next_instr  out  2      mode to PEA: 00 SETUP_INSTR, 01 INSTR, 10 OUTPUT
//  invoke      out  1      one-cycle firing pulse
//  busy        out  1      high from accepted start until DONE/ERROR
//  done        out  1      one-cycle pulse at run completion
//  error       out  1      sticky abort flag
//  err_code    out  2      00 none, 01 enable retry exhausted, 10 FC timeout
//  fire_count  out  CNT_W  completed firings this run (saturating)
//  instr_count out  IW     completed instructions this run
// BEHAVIOUR
//  Reset: state IDLE; next_instr=00, invoke=0, busy=0, done=0, error=0, err_code=00, counters 0.
//  rst overrides everything, incl. mid-run: next cycle IDLE, all outputs at reset values.
//  States: IDLE, SET_MODE, SETTLE, CHECK_EN, INVOKE, WAIT_FC, ADVANCE, DONE, ERROR.
//  IDLE/ERROR + start: latch num_instr, clear counters/error/err_code, busy=1 next cycle;
//   num_instr==0 -> DONE directly (no firings); else SET_MODE with phase=SETUP.
//  start in any other state ignored.
//  SET_MODE (1 cyc): next_instr <= phase code; registered, stable until next SET_MODE/IDLE.
//  SETTLE: count SETTLE cycles, then CHECK_EN; retry counter cleared.
//  CHECK_EN: enable=1 -> INVOKE; enable=0 -> retry++; EN_RETRY lows in a row -> ERROR, code 01.
//  INVOKE: invoke=1 exactly this cycle; FC here is stale and ignored; -> WAIT_FC, timer=0.
//  WAIT_FC: FC=1 -> fire_count++ (saturate at all-ones), -> ADVANCE;
//   timer reaches FC_TIMEOUT without FC -> ERROR, code 10.
//  ADVANCE: SETUP->INSTR; INSTR->OUTPUT if WITH_OUTPUT else end-of-instr; OUTPUT->end-of-instr.
//   end-of-instr: instr_count++; if == latched num_instr -> DONE else phase=SETUP; -> SET_MODE.
//  DONE: done=1 one cycle, busy=0, next_instr=00; -> IDLE. Counters hold until next start.
//  ERROR: busy=0, error=1 and err_code held; invoke never asserted; exits only on start or rst.
//  Invoke-to-invoke min spacing: 1 (SET_MODE)+SETTLE+1 (CHECK_EN)+>=1 (WAIT_FC)+1 (ADVANCE).
//  Inputs enable/FC assumed synchronous to clk; no internal synchronisers.
// TESTING
//  T1 num_instr=1, enable=1, FC 3 cyc after invoke -> modes 00,01; 2 invokes; fire_count=2,
//     instr_count=1, single done pulse, error=0.
//  T2 WITH_OUTPUT=1, num_instr=3 -> mode sequence 00,01,10 x3; 9 invokes; fire_count=9, done.
//  T3 enable held 0 in SETUP phase -> after 8 CHECK_EN cycles error=1, err_code=01, busy=0,
//     no invoke issued; then start with enable=1 -> error clears, run completes.
//  T4 FC never returns after first invoke -> at cycle 1024 of WAIT_FC error=1, err_code=10.
//  T5 num_instr=0 -> done pulse 2 cycles after start, zero invokes, counters 0.
//  T6 rst asserted in WAIT_FC of instr 2 of 4 -> next cycle all outputs reset; start during busy
//     ignored (no counter clear); FC during invoke cycle not counted.

Source files
------------

// File: rtl/pea_invoke_if.sv
// Handshake bundle between the PEA invoke scheduler and its host/PEA side.
// master: host/PEA side drives start/num_instr/enable/FC; slave: scheduler.
interface pea_invoke_if #(
    parameter int IW    = 5,
    parameter int CNT_W = 16
);
    logic             start;
    logic [IW-1:0]    num_instr;
    logic             enable;
    logic             FC;
    logic [1:0]       next_instr;
    logic             invoke;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] fire_count;
    logic [IW-1:0]    instr_count;

    modport master (
        output start, num_instr, enable, FC,
        input  next_instr, invoke, busy, done,
        input  error, err_code, fire_count, instr_count
    );

    modport slave (
        input  start, num_instr, enable, FC,
        output next_instr, invoke, busy, done,
        output error, err_code, fire_count, instr_count
    );
endinterface

// File: rtl/pea_invoke_scheduler.sv
// Sequences CFDF firing phases (SETUP -> INSTR [-> OUTPUT]) of the PEA.
// Ports: clk, rst (sync, active high), bus (pea_invoke_if.slave).
module pea_invoke_scheduler #(
    parameter int MAX_INSTR   = 16,
    parameter int CNT_W       = 16,
    parameter int SETTLE      = 2,
    parameter int EN_RETRY    = 8,
    parameter int FC_TIMEOUT  = 1024,
    parameter bit WITH_OUTPUT = 1'b0
) (
    input logic         clk,
    input logic         rst,
    pea_invoke_if.slave bus
);
    localparam int IW = $clog2(MAX_INSTR + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int RW = $clog2(EN_RETRY + 1);
    localparam int TW = $clog2(FC_TIMEOUT + 1);

    localparam logic [1:0] PH_SETUP = 2'b00;
    localparam logic [1:0] PH_INSTR = 2'b01;
    localparam logic [1:0] PH_OUT   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_SET_MODE, S_SETTLE, S_CHECK_EN, S_INVOKE,
        S_WAIT_FC, S_ADVANCE, S_DONE, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       mode_q, mode_d;
    logic [IW-1:0]    num_q, num_d;
    logic [IW-1:0]    instr_q, instr_d;
    logic [IW-1:0]    instr_inc;
    logic [CNT_W-1:0] fire_q, fire_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             invoke_q, invoke_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign instr_inc = instr_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        mode_d   = mode_q;
        num_d    = num_q;
        instr_d  = instr_q;
        fire_d   = fire_q;
        settle_d = settle_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        err_d    = err_q;
        code_d   = code_q;
        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (bus.start) begin
                    num_d   = bus.num_instr;
                    instr_d = '0;
                    fire_d  = '0;
                    err_d   = 1'b0;
                    code_d  = 2'b00;
                    phase_d = PH_SETUP;
                    state_d = (bus.num_instr == '0) ? S_DONE
                                                    : S_SET_MODE;
                end
            end
            S_SET_MODE: begin
                mode_d   = phase_q;
                settle_d = '0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                retry_d = '0;
                if (settle_q == SW'(SETTLE - 1)) begin
                    state_d = S_CHECK_EN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_CHECK_EN: begin
                if (bus.enable) begin
                    state_d = S_INVOKE;
                end else if (retry_q == RW'(EN_RETRY - 1)) begin
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                    state_d = S_ERROR;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
            end
            // FC seen during the invoke cycle belongs to an older firing.
            S_INVOKE: begin
                timer_d = '0;
                state_d = S_WAIT_FC;
            end
            S_WAIT_FC: begin
                if (bus.FC) begin
                    if (fire_q != '1) begin
                        fire_d = fire_q + 1'b1;
                    end
                    state_d = S_ADVANCE;
                end else if (timer_q == TW'(FC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_ADVANCE: begin
                state_d = S_SET_MODE;
                if (phase_q == PH_SETUP) begin
                    phase_d = PH_INSTR;
                end else if (phase_q == PH_INSTR && WITH_OUTPUT) begin
                    phase_d = PH_OUT;
                end else begin
                    instr_d = instr_inc;
                    phase_d = PH_SETUP;
                    if (instr_inc == num_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                mode_d  = PH_SETUP;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        invoke_d = (state_d == S_INVOKE);
        busy_d   = (state_d != S_IDLE) && (state_d != S_ERROR);
        // done lands as the scheduler returns to IDLE
        done_d   = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_SETUP;
            mode_q   <= PH_SETUP;
            num_q    <= '0;
            instr_q  <= '0;
            fire_q   <= '0;
            settle_q <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            invoke_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            num_q    <= num_d;
            instr_q  <= instr_d;
            fire_q   <= fire_d;
            settle_q <= settle_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            code_q   <= code_d;
            invoke_q <= invoke_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.next_instr  = mode_q;
    assign bus.invoke      = invoke_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = err_q;
    assign bus.err_code    = code_q;
    assign bus.fire_count  = fire_q;
    assign bus.instr_count = instr_q;
endmodule
